msd_cmd_sched: RTL and testbench

- DDR5 command scheduler between the memory-controller request queue (16-entry, 38-bit entries) and the DIMM command channel.
- Pops one request at a time, decodes bank group, bank, row and column, and issues a closed-page sequence: ACT0, ACT1, RD0/RD1 or WR0/WR1, then PRE.
- Enforces tRCD, tCL/tCWL, tBURST, tWR, tRAS and tRP in DRAM clock cycles.
- Reports completion back to the queue owner.

---
 rtl/msd_dimm_pkg.sv | 56 +++++
 rtl/msd_timing_cnt.sv | 34 +++
 rtl/msd_cmd_sched.sv | 233 +++++++++++++++++++++++
 tb/tb_msd_cmd_sched.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msd_dimm_pkg.sv
// Shared types, address layout and command encodings for the DDR5 command scheduler.
package msd_dimm_pkg;

  localparam int REQ_W   = 38;
  localparam int ADDR_W  = 36;
  localparam int BG_LSB  = 7;
  localparam int BG_W    = 3;
  localparam int BA_LSB  = 10;
  localparam int BA_W    = 2;
  localparam int COL_LSB = 12;
  localparam int COL_W   = 6;
  localparam int ROW_LSB = 18;
  localparam int ROW_W   = 16;

  typedef enum logic [1:0] {
    OP_RD  = 2'd0,
    OP_WR  = 2'd1,
    OP_IF  = 2'd2,
    OP_RSV = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_ACT0 = 3'd1,
    CMD_ACT1 = 3'd2,
    CMD_RD0  = 3'd3,
    CMD_RD1  = 3'd4,
    CMD_WR0  = 3'd5,
    CMD_WR1  = 3'd6,
    CMD_PRE  = 3'd7
  } cmd_e;

  typedef struct packed {
    op_e               op;
    logic [ADDR_W-1:0] addr;
  } req_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ACT0,
    ST_ACT1,
    ST_WAIT_RCD,
    ST_CAS0,
    ST_CAS1,
    ST_WAIT_DATA,
    ST_PRE,
    ST_WAIT_RP
  } state_e;

  // Only writes use the WR pair; ifetch and the reserved op fall back to reads.
  function automatic cmd_e cas_cmd(input op_e op, input logic second);
    if (op == OP_WR) return second ? CMD_WR1 : CMD_WR0;
    return second ? CMD_RD1 : CMD_RD0;
  endfunction

endpackage

// File: rtl/msd_timing_cnt.sv
// Loadable down-counter that parks at zero; zero_o marks an expired wait.
module msd_timing_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/msd_cmd_sched.sv
// Closed-page DDR5 command scheduler: one request at a time, ACT0/ACT1, CAS pair, PRE,
// with tRCD, CAS latency, burst, write recovery, tRAS and tRP enforced in clock cycles.
module msd_cmd_sched
  import msd_dimm_pkg::*;
#(
  parameter int TRCD   = 39,
  parameter int TCL    = 40,
  parameter int TCWL   = 38,
  parameter int TBURST = 8,
  parameter int TWR    = 48,
  parameter int TRAS   = 76,
  parameter int TRP    = 39,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [REQ_W-1:0] req_data,
  output logic             cmd_valid,
  output logic [2:0]       cmd_code,
  output logic [BG_W-1:0]  cmd_bg,
  output logic [BA_W-1:0]  cmd_ba,
  output logic [ROW_W-1:0] cmd_row,
  output logic [COL_W-1:0] cmd_col,
  output logic             cmpl_valid,
  output logic [1:0]       cmpl_op,
  output logic             op_err,
  output logic             busy
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int RD_SPAN = TCL + TBURST;
  localparam int WR_SPAN = TCWL + TBURST + TWR;

  if (CNT_W < 2 || CNT_W > 30) begin : g_bad_cnt_w
    $fatal(1, "msd_cmd_sched: CNT_W out of range");
  end
  if (TRCD < 2 || TRP < 2 || RD_SPAN < 2 || WR_SPAN < 2 || TRAS < 0) begin : g_bad_min
    $fatal(1, "msd_cmd_sched: timing parameter below its minimum");
  end
  if (TRCD > CNT_MAX || TCL > CNT_MAX || TCWL > CNT_MAX || TBURST > CNT_MAX ||
      TWR > CNT_MAX || TRAS > CNT_MAX || TRP > CNT_MAX ||
      RD_SPAN > CNT_MAX || WR_SPAN > CNT_MAX) begin : g_bad_width
    $fatal(1, "msd_cmd_sched: timing parameter does not fit CNT_W");
  end

  // A wait state of length N is entered with the counter loaded to N-1; N==0 skips the state.
  localparam bit               RCD_WAIT = (TRCD >= 3);
  localparam bit               RP_WAIT  = (TRP >= 3);
  localparam bit               RD_SHORT = (RD_SPAN <= 2);
  localparam bit               WR_SHORT = (WR_SPAN <= 2);
  localparam logic [CNT_W-1:0] RCD_LOAD = CNT_W'(RCD_WAIT ? TRCD - 3 : 0);
  localparam logic [CNT_W-1:0] RP_LOAD  = CNT_W'(RP_WAIT ? TRP - 3 : 0);
  localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(RD_SHORT ? 0 : RD_SPAN - 3);
  localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(WR_SHORT ? 0 : WR_SPAN - 3);
  localparam logic [CNT_W-1:0] RAS_THR  = CNT_W'(TRAS >= 1 ? TRAS - 1 : 0);

  state_e state_q, state_d;
  req_t   req_in;

  op_e              op_q;
  logic [BG_W-1:0]  bg_q;
  logic [BA_W-1:0]  ba_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  logic [CNT_W-1:0] ras_q;

  logic             accept;
  logic             is_wr;
  logic             ras_ok;
  logic             data_short;
  logic             wait_load;
  logic [CNT_W-1:0] wait_load_val;
  logic             wait_zero;

  logic req_ready_q, req_ready_d;
  logic cmd_valid_q, cmd_valid_d;
  cmd_e cmd_code_q, cmd_code_d;
  logic cmpl_valid_q, cmpl_valid_d;
  op_e  cmpl_op_q, cmpl_op_d;
  logic op_err_q, op_err_d;
  logic busy_q, busy_d;

  logic unused_addr_bits;

  assign req_in           = req_t'(req_data);
  assign unused_addr_bits = ^{req_in.addr[BG_LSB-1:0], req_in.addr[ADDR_W-1:ROW_LSB+ROW_W]};

  assign accept     = (state_q == ST_IDLE) && req_valid;
  assign is_wr      = (op_q == OP_WR);
  assign data_short = is_wr ? WR_SHORT : RD_SHORT;
  // ras_q counts cycles since ACT0, so ras_q >= TRAS-1 lets PRE land at A0+TRAS or later.
  assign ras_ok     = (ras_q >= RAS_THR);

  msd_timing_cnt #(
    .W (CNT_W)
  ) u_wait_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (wait_load),
    .load_val_i (wait_load_val),
    .zero_o     (wait_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_load     = 1'b0;
    wait_load_val = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) state_d = ST_ACT0;
      end
      ST_ACT0: state_d = ST_ACT1;
      ST_ACT1: begin
        if (RCD_WAIT) begin
          state_d       = ST_WAIT_RCD;
          wait_load     = 1'b1;
          wait_load_val = RCD_LOAD;
        end else begin
          state_d = ST_CAS0;
        end
      end
      ST_WAIT_RCD: begin
        if (wait_zero) state_d = ST_CAS0;
      end
      ST_CAS0: state_d = ST_CAS1;
      ST_CAS1: begin
        if (data_short && ras_ok) begin
          state_d = ST_PRE;
        end else begin
          state_d       = ST_WAIT_DATA;
          wait_load     = 1'b1;
          wait_load_val = is_wr ? WR_LOAD : RD_LOAD;
        end
      end
      ST_WAIT_DATA: begin
        if (wait_zero && ras_ok) state_d = ST_PRE;
      end
      ST_PRE: begin
        if (RP_WAIT) begin
          state_d       = ST_WAIT_RP;
          wait_load     = 1'b1;
          wait_load_val = RP_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_RP: begin
        if (wait_zero) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    cmd_code_d = CMD_NOP;
    case (state_d)
      ST_ACT0: cmd_code_d = CMD_ACT0;
      ST_ACT1: cmd_code_d = CMD_ACT1;
      ST_CAS0: cmd_code_d = cas_cmd(op_q, 1'b0);
      ST_CAS1: cmd_code_d = cas_cmd(op_q, 1'b1);
      ST_PRE:  cmd_code_d = CMD_PRE;
      default: cmd_code_d = CMD_NOP;
    endcase
    cmd_valid_d  = (cmd_code_d != CMD_NOP);
    cmpl_valid_d = (state_d == ST_PRE);
    cmpl_op_d    = cmpl_valid_d ? op_q : OP_RD;
    op_err_d     = accept && (req_in.op == OP_RSV);
    req_ready_d  = (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q         <= OP_RD;
      bg_q         <= '0;
      ba_q         <= '0;
      row_q        <= '0;
      col_q        <= '0;
      ras_q        <= '0;
      req_ready_q  <= 1'b1;
      cmd_valid_q  <= 1'b0;
      cmd_code_q   <= CMD_NOP;
      cmpl_valid_q <= 1'b0;
      cmpl_op_q    <= OP_RD;
      op_err_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= req_in.op;
        bg_q  <= req_in.addr[BG_LSB +: BG_W];
        ba_q  <= req_in.addr[BA_LSB +: BA_W];
        row_q <= req_in.addr[ROW_LSB +: ROW_W];
        col_q <= req_in.addr[COL_LSB +: COL_W];
      end
      if (state_d == ST_ACT0) begin
        ras_q <= '0;
      end else if (ras_q != '1) begin
        ras_q <= ras_q + 1'b1;
      end
      req_ready_q  <= req_ready_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_code_q   <= cmd_code_d;
      cmpl_valid_q <= cmpl_valid_d;
      cmpl_op_q    <= cmpl_op_d;
      op_err_q     <= op_err_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_code   = cmd_code_q;
  assign cmd_bg     = bg_q;
  assign cmd_ba     = ba_q;
  assign cmd_row    = row_q;
  assign cmd_col    = col_q;
  assign cmpl_valid = cmpl_valid_q;
  assign cmpl_op    = cmpl_op_q;
  assign op_err     = op_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_msd_cmd_sched.sv
// Bench for msd_cmd_sched: cycle-level reference model plus table vectors and corner sequences.
module tb_msd_cmd_sched;

  localparam int TRCD = 39, TCL = 40, TCWL = 38, TBURST = 8, TWR = 48, TRAS = 76, TRP = 39;
  localparam logic [36:0] RESET_VEC = 37'h10_0000_0000;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready;
  logic [37:0] req_data;
  logic        cmd_valid;
  logic [2:0]  cmd_code, cmd_bg;
  logic [1:0]  cmd_ba, cmpl_op;
  logic [15:0] cmd_row;
  logic [5:0]  cmd_col;
  logic        cmpl_valid, op_err, busy;

  logic        rv2, req_ready_b;
  logic [37:0] rd2;
  logic        cmd_valid_b;
  logic [2:0]  cmd_code_b, cmd_bg_b;
  logic [1:0]  cmd_ba_b, cmpl_op_b;
  logic [15:0] cmd_row_b;
  logic [5:0]  cmd_col_b;
  logic        cmpl_valid_b, op_err_b, busy_b;

  msd_cmd_sched #(.TRCD(TRCD), .TCL(TCL), .TCWL(TCWL), .TBURST(TBURST), .TWR(TWR),
                  .TRAS(TRAS), .TRP(TRP), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_bg(cmd_bg), .cmd_ba(cmd_ba),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .cmpl_valid(cmpl_valid), .cmpl_op(cmpl_op),
    .op_err(op_err), .busy(busy));

  // Short-latency instance where tRAS, not the data phase, decides the PRE cycle.
  msd_cmd_sched #(.TRCD(4), .TCL(4), .TCWL(TCWL), .TBURST(2), .TWR(TWR),
                  .TRAS(TRAS), .TRP(TRP), .CNT_W(8)) dut_ras (
    .clk(clk), .rst(rst), .req_valid(rv2), .req_ready(req_ready_b), .req_data(rd2),
    .cmd_valid(cmd_valid_b), .cmd_code(cmd_code_b), .cmd_bg(cmd_bg_b), .cmd_ba(cmd_ba_b),
    .cmd_row(cmd_row_b), .cmd_col(cmd_col_b), .cmpl_valid(cmpl_valid_b), .cmpl_op(cmpl_op_b),
    .op_err(op_err_b), .busy(busy_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: the current request's accept cycle, op and address.
  bit          m_valid = 0;
  int          m_t     = 0;
  logic [1:0]  m_op    = 2'd0;
  logic [35:0] m_addr  = '0;

  int ev[8], ev2[8];
  int ev_base, ev_cmpl, ev_cop, ev_err, ev_rdy, act0_2, low_cnt, ev2_rdy, ev2_cop;
  int f_bg, f_ba, f_row, f_col;

  function automatic int m_pre();
    int c0, span;
    c0   = m_t + 1 + TRCD;
    span = (m_op == 2'd1) ? (TCWL + TBURST + TWR) : (TCL + TBURST);
    return (c0 + span > m_t + 1 + TRAS) ? c0 + span : m_t + 1 + TRAS;
  endfunction

  function automatic bit m_idle(int c);
    return !m_valid || (c >= m_pre() + TRP - 1);
  endfunction

  function automatic logic [36:0] m_expect(int c);
    int a0, c0, p;
    logic [2:0] code;
    logic bsy, cv, oe;
    code = 3'd0; bsy = 1'b0; cv = 1'b0; oe = 1'b0;
    if (m_valid) begin
      a0 = m_t + 1;
      c0 = a0 + TRCD;
      p  = m_pre();
      bsy = (c >= a0) && (c < p + TRP - 1);
      if (c == a0) code = 3'd1;
      else if (c == a0 + 1) code = 3'd2;
      else if (c == c0) code = (m_op == 2'd1) ? 3'd5 : 3'd3;
      else if (c == c0 + 1) code = (m_op == 2'd1) ? 3'd6 : 3'd4;
      else if (c == p) code = 3'd7;
      cv = (c == p);
      oe = (c == a0) && (m_op == 2'd3);
    end
    return {~bsy, bsy, code != 3'd0, code, m_addr[9:7], m_addr[11:10], m_addr[33:18],
            m_addr[17:12], cv, cv ? m_op : 2'b00, oe};
  endfunction

  function automatic logic [36:0] dut_vec();
    return {req_ready, busy, cmd_valid, cmd_code, cmd_bg, cmd_ba, cmd_row, cmd_col,
            cmpl_valid, cmpl_valid ? cmpl_op : 2'b00, op_err};
  endfunction

  task automatic cmp(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic clear_ev();
    for (int i = 0; i < 8; i++) begin ev[i] = -1; ev2[i] = -1; end
    ev_base = cyc; ev_cmpl = -1; ev_cop = -1; ev_err = -1; ev_rdy = -1;
    act0_2 = -1; low_cnt = 0; ev2_rdy = -1; ev2_cop = -1;
    f_bg = -1; f_ba = -1; f_row = -1; f_col = -1;
  endtask

  task automatic record();
    int rel;
    rel = cyc - ev_base;
    if (cmd_valid) begin
      if (ev[cmd_code] < 0) begin
        ev[cmd_code] = rel;
        if (cmd_code == 3'd1) begin
          f_bg = int'(cmd_bg); f_ba = int'(cmd_ba); f_row = int'(cmd_row); f_col = int'(cmd_col);
        end
      end else if (cmd_code == 3'd1 && act0_2 < 0) begin
        act0_2 = rel;
      end
    end
    if (cmpl_valid && ev_cmpl < 0) begin ev_cmpl = rel; ev_cop = int'(cmpl_op); end
    if (op_err && ev_err < 0) ev_err = rel;
    if (rel > 0 && req_ready && ev_rdy < 0) ev_rdy = rel;
    if (rel > 0 && rel <= 125 && !req_ready) low_cnt++;
    if (cmd_valid_b && ev2[cmd_code_b] < 0) ev2[cmd_code_b] = rel;
    if (cmpl_valid_b && ev2_cop < 0) ev2_cop = int'(cmpl_op_b);
    if (rel > 0 && req_ready_b && ev2_rdy < 0) ev2_rdy = rel;
    if (cmpl_valid)
      $display("txn cyc=%0d op=%0d bg=%0d ba=%0d row=%h col=%h",
               cyc, cmpl_op, cmd_bg, cmd_ba, cmd_row, cmd_col);
  endtask

  // Advance one clock: model absorbs this cycle's inputs, then DUT outputs are compared.
  task automatic tick(input bit chk);
    logic [36:0] g, e;
    if (rst) begin
      m_valid = 0; m_op = 2'd0; m_addr = '0;
    end else if (req_valid && m_idle(cyc)) begin
      m_valid = 1; m_t = cyc; m_op = req_data[37:36]; m_addr = req_data[35:0];
    end
    @(posedge clk);
    #1;
    cyc++;
    record();
    if (chk) begin
      g = dut_vec();
      e = m_expect(cyc);
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL outputs cyc=%0d: got %h expected %h", cyc, g, e);
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && !req_ready; i++) tick(1);
    total++;
    if (!req_ready) begin
      bad++;
      $display("FAIL wait_idle: req_ready got 0 expected 1");
    end
  endtask

  typedef struct {
    logic [37:0] data;
    int cas, c0, pre, rdy, cop, err, bg, ba, row, col;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [1:0]  op_r;
    logic [35:0] a_r;
    vecs[0] = '{data: 38'h0_0004_5680, cas: 3, c0: 40, pre: 88, rdy: 126, cop: 0, err: 0,
                bg: 5, ba: 1, row: 1, col: 5};
    vecs[1] = '{data: {2'b01, 36'h0_0004_5680}, cas: 5, c0: 40, pre: 134, rdy: 172, cop: 1,
                err: 0, bg: 5, ba: 1, row: 1, col: 5};
    vecs[2] = '{data: {2'b10, 36'hF_FFFF_FFFF}, cas: 3, c0: 40, pre: 88, rdy: 126, cop: 2,
                err: 0, bg: 7, ba: 3, row: 16'hFFFF, col: 6'h3F};
    vecs[3] = '{data: {2'b11, 36'h2_AAAA_5555}, cas: 3, c0: 40, pre: 88, rdy: 126, cop: 3,
                err: 1, bg: 2, ba: 1, row: 16'hAAAA, col: 6'h25};

    rst = 1'b1; req_valid = 1'b0; req_data = '0; rv2 = 1'b0; rd2 = '0;
    clear_ev();
    tick(0);
    tick(0);
    tick(1);
    cmp("reset state", int'(dut_vec() == RESET_VEC), 1);
    rst = 1'b0;
    tick(1);

    // Table vectors: one request each, event cycles relative to the accept cycle.
    for (int i = 0; i < 4; i++) begin
      wait_idle();
      clear_ev();
      req_valid = 1'b1;
      req_data  = vecs[i].data;
      tick(1);
      req_valid = 1'b0;
      for (int k = 0; k < vecs[i].rdy + 1; k++) begin
        req_data = 38'({$urandom(), $urandom()});
        tick(1);
      end
      cmp($sformatf("v%0d act0", i), ev[1], 1);
      cmp($sformatf("v%0d act1", i), ev[2], 2);
      cmp($sformatf("v%0d cas0", i), ev[vecs[i].cas], vecs[i].c0);
      cmp($sformatf("v%0d cas1", i), ev[vecs[i].cas + 1], vecs[i].c0 + 1);
      cmp($sformatf("v%0d pre", i), ev[7], vecs[i].pre);
      cmp($sformatf("v%0d cmpl", i), ev_cmpl, vecs[i].pre);
      cmp($sformatf("v%0d cmpl_op", i), ev_cop, vecs[i].cop);
      cmp($sformatf("v%0d op_err", i), ev_err, vecs[i].err ? 1 : -1);
      cmp($sformatf("v%0d ready", i), ev_rdy, vecs[i].rdy);
      cmp($sformatf("v%0d fields", i), int'({f_bg, f_ba, f_row, f_col} ==
          {vecs[i].bg, vecs[i].ba, vecs[i].row, vecs[i].col}), 1);
    end

    // Back-to-back reads with req_valid held high.
    wait_idle();
    clear_ev();
    req_valid = 1'b1;
    req_data  = 38'h0_0004_5680;
    for (int k = 0; k < 130; k++) tick(1);
    req_valid = 1'b0;
    cmp("b2b act0 first", ev[1], 1);
    cmp("b2b act0 second", act0_2, 127);
    cmp("b2b ready low cycles", low_cnt, 125);
    cmp("b2b ready back", ev_rdy, 126);
    wait_idle();

    // tRAS-dominant instance.
    clear_ev();
    rv2 = 1'b1;
    rd2 = 38'h0_0004_5680;
    tick(1);
    rv2 = 1'b0;
    for (int k = 0; k < 120; k++) tick(1);
    cmp("ras rd0", ev2[3], 5);
    cmp("ras rd1", ev2[4], 6);
    cmp("ras pre", ev2[7], 77);
    cmp("ras cmpl_op", ev2_cop, 0);
    cmp("ras ready back", ev2_rdy, 115);

    // Reset in the middle of WAIT_RCD, then an immediate new request.
    wait_idle();
    clear_ev();
    req_valid = 1'b1;
    req_data  = {2'b01, 36'h5_1234_5678};
    tick(1);
    req_valid = 1'b0;
    for (int k = 1; k < 20; k++) tick(1);
    rst = 1'b1;
    tick(1);
    cmp("mid reset outputs", int'(dut_vec() == RESET_VEC), 1);
    rst = 1'b0;
    req_valid = 1'b1;
    req_data  = 38'h0_0004_5680;
    tick(1);
    req_valid = 1'b0;
    cmp("post reset act0", int'(cmd_code), 1);
    cmp("post reset act0 cycle", cyc - ev_base, 22);
    for (int k = 0; k < 140; k++) tick(1);
    cmp("post reset pre", ev[7], 21 + 88);
    wait_idle();

    // Randomized traffic with occasional resets, checked every cycle by the model.
    for (int k = 0; k < 2000; k++) begin
      op_r      = 2'($urandom_range(0, 3));
      a_r       = 36'({$urandom(), $urandom()});
      req_valid = ($urandom_range(0, 2) != 0);
      req_data  = {op_r, a_r};
      rst       = ($urandom_range(0, 399) == 0);
      tick(1);
    end
    rst = 1'b0;
    req_valid = 1'b0;
    tick(1);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
